// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side definitions: PC constants and the PC sequencer state enum.
// TRAP_WAIT is only present when MISALIGN_TRAP_EN is defined.
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC           = 32'd4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT      = 2'd0,
      RUN       = 2'd1
`ifdef MISALIGN_TRAP_EN
      ,
      TRAP_WAIT = 2'd2
`endif
   } pc_state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential/branch/JALR next-PC selection, flush generation, redirect counter.
// Define MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_VEC and wait for trap_ack.
module pc_redirect_ctrl
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_f,
   input  logic             branch_taken_e,
   input  logic             jump_e,
   input  logic             jalr_e,
   input  logic [XLEN-1:0]  pc_target_e,
   input  logic [XLEN-1:0]  pc_jalr_e,
   input  logic             trap_ack,
   output logic [XLEN-1:0]  pc_f,
   output logic [XLEN-1:0]  pc_plus4_f,
   output logic             fetch_en,
   output logic             flush_d,
   output logic             flush_e,
   output logic             redirect,
   output logic             misalign,
   output logic [CNT_W-1:0] redirect_cnt
);

   pc_state_t       state_d;
   pc_state_t       state_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_q;
   logic            req;
   logic [XLEN-1:0] target;

   assign req        = jalr_e | jump_e | branch_taken_e;
   assign target     = jalr_e ? pc_jalr_e : pc_target_e;
   assign pc_f       = pc_q;
   assign pc_plus4_f = pc_q + PC_INC;

   // Flush/redirect/misalign are combinational so both younger instructions die in the request cycle.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fetch_en = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      redirect = 1'b0;
      misalign = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            fetch_en = 1'b1;
            if (req) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
`ifdef MISALIGN_TRAP_EN
               if (target[1]) begin
                  misalign = 1'b1;
                  pc_d     = TRAP_VEC;
                  state_d  = TRAP_WAIT;
               end else begin
                  redirect = 1'b1;
                  pc_d     = target;
               end
`else
               redirect = 1'b1;
               pc_d     = target;
`endif
            end else if (!stall_f) begin
               pc_d = pc_plus4_f;
            end
         end
`ifdef MISALIGN_TRAP_EN
         TRAP_WAIT: begin
            if (trap_ack) begin
               state_d = RUN;
            end
         end
`endif
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifndef MISALIGN_TRAP_EN
   // Trap vector and acknowledge have no function without the trap feature.
   logic unused_trap;
   assign unused_trap = trap_ack ^ (^TRAP_VEC);
`endif

   sat_counter #(
      .W(CNT_W)
   ) u_redirect_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (redirect),
      .count(redirect_cnt)
   );

endmodule
